// File: rtl/sb_config_loader.sv
// Serial configuration loader for the fabric switch boxes: locks onto a sync byte, then
// assembles even-parity-checked CFG_W-bit words and commits one word per switch box.
module sb_config_loader #(
    parameter int         NUM_SB = 4,
    parameter int         CFG_W  = 30,
    parameter logic [7:0] SYNC   = 8'hA5
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    cfg_start,
    input  logic                    cfg_valid,
    input  logic                    cfg_bit,
    output logic                    cfg_ready,
    output logic [NUM_SB*CFG_W-1:0] roofconn_flat,
    output logic [NUM_SB-1:0]       sb_load,
    output logic                    cfg_done,
    output logic                    cfg_err
);
    localparam int BOX_W = (NUM_SB > 1) ? $clog2(NUM_SB) : 1;
    localparam int CNT_W = 5;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CFG_W - 1);
    localparam logic [BOX_W-1:0] BOX_LAST = BOX_W'(NUM_SB - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SYNC   = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_DONE   = 3'd4,
        S_ERR    = 3'd5
    } state_t;

    function automatic logic even_parity_ok(input logic acc, input logic par_bit);
        return (acc ^ par_bit) == 1'b0;
    endfunction

    state_t             state_r, state_s;
    // Only the last seven bits are stored; the eighth bit of the window is the incoming one.
    logic [6:0]         win_r, win_s;
    logic [CNT_W-1:0]   cnt_r, cnt_s;
    logic [BOX_W-1:0]   box_r, box_s;
    logic               par_r, par_s;
    logic [CFG_W-1:0]   shreg_r, shreg_s;
    logic               commit_r, commit_s;
    logic [BOX_W-1:0]   commit_box_r, commit_box_s;
    logic               take_s;

    assign take_s = cfg_valid & cfg_ready & ~cfg_start;

    // Next-state and datapath decode; cfg_start has priority over any presented bit.
    always_comb begin
        state_s      = state_r;
        win_s        = win_r;
        cnt_s        = cnt_r;
        box_s        = box_r;
        par_s        = par_r;
        shreg_s      = shreg_r;
        commit_s     = 1'b0;
        commit_box_s = commit_box_r;
        if (cfg_start) begin
            state_s = S_SYNC;
            win_s   = 7'd0;
            cnt_s   = '0;
            box_s   = '0;
            par_s   = 1'b0;
        end else if (take_s) begin
            case (state_r)
                S_SYNC: begin
                    win_s = {win_r[5:0], cfg_bit};
                    if ({win_r, cfg_bit} == SYNC) begin
                        state_s = S_DATA;
                        cnt_s   = '0;
                        box_s   = '0;
                        par_s   = 1'b0;
                    end else begin
                        state_s = S_SYNC;
                    end
                end
                S_DATA: begin
                    shreg_s = {shreg_r[CFG_W-2:0], cfg_bit};
                    par_s   = par_r ^ cfg_bit;
                    if (cnt_r == CNT_LAST) begin
                        state_s = S_PARITY;
                        cnt_s   = '0;
                    end else begin
                        cnt_s = cnt_r + 5'd1;
                    end
                end
                S_PARITY: begin
                    par_s = 1'b0;
                    if (even_parity_ok(par_r, cfg_bit)) begin
                        commit_s     = 1'b1;
                        commit_box_s = box_r;
                        if (box_r == BOX_LAST) begin
                            state_s = S_DONE;
                        end else begin
                            box_s   = box_r + 1'b1;
                            state_s = S_DATA;
                        end
                    end else begin
                        state_s = S_ERR;
                    end
                end
                default: state_s = state_r;
            endcase
        end else begin
            state_s = state_r;
        end
    end

    // FSM and datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= S_IDLE;
            win_r        <= 7'd0;
            cnt_r        <= '0;
            box_r        <= '0;
            par_r        <= 1'b0;
            shreg_r      <= '0;
            commit_r     <= 1'b0;
            commit_box_r <= '0;
        end else begin
            state_r      <= state_s;
            win_r        <= win_s;
            cnt_r        <= cnt_s;
            box_r        <= box_s;
            par_r        <= par_s;
            shreg_r      <= shreg_s;
            commit_r     <= commit_s;
            commit_box_r <= commit_box_s;
        end
    end

    // Registered outputs: state decode plus the delayed commit of an accepted word.
    always_ff @(posedge clk) begin
        if (reset) begin
            roofconn_flat <= '0;
            sb_load       <= '0;
            cfg_ready     <= 1'b0;
            cfg_done      <= 1'b0;
            cfg_err       <= 1'b0;
        end else begin
            cfg_ready <= (state_r == S_SYNC) || (state_r == S_DATA) || (state_r == S_PARITY);
            cfg_done  <= (state_r == S_DONE);
            cfg_err   <= (state_r == S_ERR);
            for (int k = 0; k < NUM_SB; k++) begin
                // shreg_r still holds the committed word here even if the next box starts shifting.
                if (commit_r && (commit_box_r == BOX_W'(k))) begin
                    roofconn_flat[k*CFG_W +: CFG_W] <= shreg_r;
                    sb_load[k]                      <= 1'b1;
                end else begin
                    sb_load[k] <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_sb_config_loader.sv
// Bench for sb_config_loader: streams are decoded by a bit-level reference model into expected
// commits, and a negedge monitor compares every sb_load strobe against that scoreboard.
module tb_sb_config_loader;
    localparam int         NSB      = 4;
    localparam int         W        = 30;
    localparam logic [7:0] SYNC_PAT = 8'hA5;

    typedef struct packed {
        logic [7:0]   box;
        logic [W-1:0] word;
    } exp_t;

    logic            clk = 1'b0;
    logic            reset, cfg_start, cfg_valid, cfg_bit;
    logic            cfg_ready, cfg_done, cfg_err;
    logic [NSB*W-1:0] roofconn_flat;
    logic [NSB-1:0]  sb_load;
    logic            cfg_ready1, cfg_done1, cfg_err1;
    logic [W-1:0]    roof1;
    logic [0:0]      sb_load1;

    int   nvec = 0, nerr = 0, cyc = 0;
    int   t_first = 0, done_cyc = -1, m_len = 0;
    bit   first_pending = 1'b0, done_prev = 1'b0, m_done = 1'b0, m_err = 1'b0;
    logic stream[$];
    exp_t exp_q[$];
    exp_t mon_e;
    int   strobe_cyc[$];
    logic [W-1:0] model_roof [NSB];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sb_config_loader #(.NUM_SB(NSB), .CFG_W(W), .SYNC(SYNC_PAT)) dut (
        .clk(clk), .reset(reset), .cfg_start(cfg_start), .cfg_valid(cfg_valid), .cfg_bit(cfg_bit),
        .cfg_ready(cfg_ready), .roofconn_flat(roofconn_flat), .sb_load(sb_load),
        .cfg_done(cfg_done), .cfg_err(cfg_err)
    );

    sb_config_loader #(.NUM_SB(1), .CFG_W(W), .SYNC(SYNC_PAT)) dut1 (
        .clk(clk), .reset(reset), .cfg_start(cfg_start), .cfg_valid(cfg_valid), .cfg_bit(cfg_bit),
        .cfg_ready(cfg_ready1), .roofconn_flat(roof1), .sb_load(sb_load1),
        .cfg_done(cfg_done1), .cfg_err(cfg_err1)
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every strobe must match the oldest expected commit.
    always @(negedge clk) begin
        if (!reset) begin
            if (sb_load !== '0) begin
                strobe_cyc.push_back(cyc);
                if (exp_q.size() == 0) begin
                    check("unexpected sb_load", 128'(sb_load), 128'(0));
                end else begin
                    mon_e = exp_q.pop_front();
                    check("sb_load onehot", 128'(sb_load), 128'(1) << mon_e.box);
                    check("roofconn slice", 128'(roofconn_flat[mon_e.box*W +: W]), 128'(mon_e.word));
                end
            end
            if (cfg_done && !done_prev) done_cyc = cyc;
            done_prev = cfg_done;
        end
    end

    // Reference: scan for the sync byte (window starts cleared), then take 31-bit groups.
    function automatic void model_frame();
        logic [7:0]   win = 8'h00;
        logic [W-1:0] w;
        int           i = 0;
        bit           locked = 1'b0;
        m_done = 1'b0;
        m_err  = 1'b0;
        m_len  = stream.size();
        while (i < stream.size() && !locked) begin
            win = {win[6:0], stream[i]};
            i++;
            if (win == SYNC_PAT) locked = 1'b1;
        end
        if (!locked) return;
        for (int k = 0; k < NSB; k++) begin
            if (i + W + 1 > stream.size()) return;
            for (int j = 0; j < W; j++) w[W-1-j] = stream[i+j];
            i = i + W;
            if (((^w) ^ stream[i]) != 1'b0) begin
                m_err = 1'b1;
                m_len = i + 1;
                return;
            end
            i++;
            exp_q.push_back('{box: 8'(k), word: w});
            model_roof[k] = w;
        end
        m_done = 1'b1;
        m_len  = i;
    endfunction

    task automatic push_bits(input logic [63:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) stream.push_back(v[i]);
    endtask

    task automatic push_box(input logic [W-1:0] w, input bit flip);
        push_bits(64'(w), W);
        stream.push_back((^w) ^ flip);
    endtask

    task automatic send_bit(input logic b, input bit rnd);
        int tries = 0;
        forever begin
            @(negedge clk);
            cfg_bit   = b;
            cfg_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (cfg_valid && cfg_ready) break;
            tries++;
            if (tries > 200) begin
                check("ready timeout", 128'(cfg_ready), 128'(1));
                break;
            end
        end
        if (first_pending) begin
            t_first       = cyc;
            first_pending = 1'b0;
        end
    endtask

    task automatic drive_stream(input bit rnd);
        for (int i = 0; i < m_len; i++) send_bit(stream[i], rnd);
        @(negedge clk);
        cfg_valid = 1'b0;
    endtask

    task automatic pulse_start(input logic with_valid, input logic b);
        @(negedge clk);
        cfg_start = 1'b1;
        cfg_valid = with_valid;
        cfg_bit   = b;
        @(negedge clk);
        cfg_start = 1'b0;
        cfg_valid = 1'b0;
    endtask

    task automatic outputs_zero(input string tag);
        check({tag, " ready"}, 128'(cfg_ready), 128'(0));
        check({tag, " done"}, 128'(cfg_done), 128'(0));
        check({tag, " err"}, 128'(cfg_err), 128'(0));
        check({tag, " sb_load"}, 128'(sb_load), 128'(0));
        check({tag, " roofconn"}, 128'(roofconn_flat), 128'(0));
    endtask

    task automatic check_final(input string tag, input logic exp_ready);
        logic [NSB*W-1:0] mf;
        repeat (4) @(negedge clk);
        for (int k = 0; k < NSB; k++) mf[k*W +: W] = model_roof[k];
        check({tag, " roofconn"}, 128'(roofconn_flat), 128'(mf));
        check({tag, " done"}, 128'(cfg_done), 128'(m_done));
        check({tag, " err"}, 128'(cfg_err), 128'(m_err));
        check({tag, " ready"}, 128'(cfg_ready), 128'(exp_ready));
        check({tag, " scoreboard drained"}, 128'(exp_q.size()), 128'(0));
    endtask

    initial begin
        #5_000_000;
        $display("FAIL global timeout: %0d vectors so far", nvec);
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; cfg_start = 1'b0; cfg_valid = 1'b0; cfg_bit = 1'b0;
        for (int k = 0; k < NSB; k++) model_roof[k] = '0;
        repeat (3) @(negedge clk);
        outputs_zero("reset");
        reset = 1'b0;

        // Single box on the NUM_SB=1 instance; the 4-box instance loads box 0 from the same stream.
        stream.delete();
        push_bits(64'hA5, 8); push_bits(64'h1249, W); push_bits(64'h1, 1);
        model_frame();
        pulse_start(1'b0, 1'b0);
        drive_stream(1'b0);
        check("nsb1 sb_load early", 128'(sb_load1), 128'(0));
        check("nsb1 done early", 128'(cfg_done1), 128'(0));
        @(negedge clk);
        check("nsb1 sb_load", 128'(sb_load1), 128'(1));
        check("nsb1 roofconn", 128'(roof1), 128'(30'h00001249));
        check("nsb1 done", 128'(cfg_done1), 128'(1));
        @(negedge clk);
        check("nsb1 sb_load width", 128'(sb_load1), 128'(0));
        check("nsb1 done level", 128'(cfg_done1), 128'(1));
        check_final("single", !(m_done | m_err));

        // Full frame, valid held high: strobe spacing and done latency.
        stream.delete();
        push_bits(64'(SYNC_PAT), 8);
        push_box(30'h1, 1'b0); push_box(30'h2, 1'b0); push_box(30'h3FFFFFFF, 1'b0); push_box(30'h0, 1'b0);
        model_frame();
        strobe_cyc.delete(); done_cyc = -1;
        pulse_start(1'b0, 1'b0);
        first_pending = 1'b1;
        drive_stream(1'b0);
        check_final("full", !(m_done | m_err));
        check("full strobe count", 128'(strobe_cyc.size()), 128'(4));
        if (strobe_cyc.size() == 4) begin
            check("first strobe latency", 128'(strobe_cyc[0] - t_first), 128'(40));
            for (int i = 1; i < 4; i++)
                check("strobe spacing", 128'(strobe_cyc[i] - strobe_cyc[i-1]), 128'(31));
        end
        check("done latency", 128'(done_cyc - t_first), 128'(133));

        // Reset in the middle of a frame, then bits ignored until cfg_start.
        stream.delete();
        push_bits(64'(SYNC_PAT), 8); push_bits(64'($urandom), 10);
        model_frame();
        pulse_start(1'b0, 1'b0);
        drive_stream(1'b0);
        @(negedge clk); reset = 1'b1;
        @(negedge clk); outputs_zero("mid-frame reset");
        @(negedge clk); reset = 1'b0;
        for (int k = 0; k < NSB; k++) model_roof[k] = '0;
        repeat (20) begin
            @(negedge clk);
            cfg_valid = 1'b1;
            cfg_bit   = 1'($urandom_range(0, 1));
        end
        @(negedge clk); cfg_valid = 1'b0;
        m_done = 1'b0; m_err = 1'b0;
        check_final("after reset", 1'b0);

        // Parity error on box 2.
        stream.delete();
        push_bits(64'(SYNC_PAT), 8);
        push_box(30'h1, 1'b0); push_box(30'h2, 1'b0); push_box(30'h3FFFFFFF, 1'b1); push_box(30'h0, 1'b0);
        model_frame();
        pulse_start(1'b0, 1'b0);
        drive_stream(1'b0);
        check_final("parity err", 1'b0);

        // D2 then A5: A5 already appears at bits 1..8, so the model decides where lock happens.
        for (int r = 0; r < 2; r++) begin
            stream.delete();
            push_bits(64'hD2, 8); push_bits(64'(SYNC_PAT), 8);
            push_box(30'h15555555, 1'b0); push_box(30'h0ABCDEF1, 1'b0);
            push_box(30'h2468ACE0, 1'b0); push_box(30'h13579BDF, 1'b0);
            model_frame();
            pulse_start(1'b0, 1'b0);
            drive_stream(r == 1);
            check_final(r == 0 ? "noise full-rate" : "noise half-rate", !(m_done | m_err));
        end

        // Restart collision in the middle of box 1, then a fresh frame without another start.
        stream.delete();
        push_bits(64'(SYNC_PAT), 8); push_box(30'h2AAA5555, 1'b0); push_bits(64'h7FFF, 15);
        model_frame();
        pulse_start(1'b0, 1'b0);
        drive_stream(1'b0);
        pulse_start(1'b1, 1'b1);
        m_done = 1'b0; m_err = 1'b0;
        check_final("collision", 1'b1);
        stream.delete();
        push_bits(64'(SYNC_PAT), 8);
        for (int k = 0; k < NSB; k++) push_box(W'($urandom), 1'b0);
        model_frame();
        drive_stream(1'b0);
        check_final("after collision", !(m_done | m_err));

        // Randomized frames: noise prefix, random words, occasional parity flip, random duty.
        for (int f = 0; f < 8; f++) begin
            stream.delete();
            push_bits(64'($urandom), $urandom_range(0, 12));
            push_bits(64'(SYNC_PAT), 8);
            for (int k = 0; k < NSB; k++) begin
                bit flip;
                flip = ($urandom_range(0, 5) == 0);
                push_box(W'($urandom), flip);
                if (flip) break;
            end
            model_frame();
            pulse_start(1'b0, 1'b0);
            drive_stream(1'($urandom_range(0, 1)));
            check_final("random frame", !(m_done | m_err));
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
